// File: rtl/led_pattern_driver.sv
// -----------------------------------------------------------------------------
// led_pattern_driver
// Drives NUM_LEDS board LEDs from a latched pattern in one of four animation
// modes (STATIC, BLINK, ROTATE, BOUNCE). A global PWM stage dims all LEDs.
// The animation timebase comes from an internal free-running prescaler.
//
// Ports
//   clk          system clock
//   rstn         asynchronous reset, active low
//   cfg_load     1-cycle strobe: capture cfg_mode / cfg_pattern, restart timebase
//   cfg_mode     0 STATIC, 1 BLINK, 2 ROTATE, 3 BOUNCE
//   cfg_pattern  starting pattern for the selected mode
//   brightness   PWM duty level, used live every cycle
//   step_tick    1-cycle pulse marking each animation step
//   led          registered LED drive, 1 = on
// -----------------------------------------------------------------------------
module led_pattern_driver #(
    parameter int                  NUM_LEDS      = 4,
    parameter int                  DIV_BITS      = 22,
    parameter int                  PWM_BITS      = 4,
    parameter logic [NUM_LEDS-1:0] RESET_PATTERN = {{(NUM_LEDS-1){1'b0}}, 1'b1},
    parameter logic [1:0]          RESET_MODE    = 2'd0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_load,
    input  logic [1:0]          cfg_mode,
    input  logic [NUM_LEDS-1:0] cfg_pattern,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                step_tick,
    output logic [NUM_LEDS-1:0] led
);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [DIV_BITS-1:0] PRESC_MAX = {DIV_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};

    // State registers
    logic [DIV_BITS-1:0] r_prescaler;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_pat;
    logic [1:0]          r_mode;
    logic                r_dir;
    logic                r_blink_on;
    logic                r_step_tick;
    logic [NUM_LEDS-1:0] r_led;

    // Next-state / combinational signals
    logic [DIV_BITS-1:0] w_prescaler_next;
    logic [NUM_LEDS-1:0] w_pat_next;
    logic [1:0]          w_mode_next;
    logic                w_dir_next;
    logic                w_blink_on_next;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_rot_left;
    logic [NUM_LEDS-1:0] w_shl;
    logic [NUM_LEDS-1:0] w_shr;
    logic [NUM_LEDS-1:0] w_vis;
    logic                w_pwm_en;

    // The step happens on the edge that ends the all-ones prescaler cycle,
    // which is exactly the cycle in which step_tick is high.
    assign w_tick = (r_prescaler == PRESC_MAX);

    // Shift / rotate networks, one bit per LED.
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign w_rot_left[gi] = r_pat[NUM_LEDS-1];
                assign w_shl[gi]      = 1'b0;
                assign w_shr[gi]      = r_pat[gi+1];
            end else if (gi == NUM_LEDS-1) begin : g_msb
                assign w_rot_left[gi] = r_pat[gi-1];
                assign w_shl[gi]      = r_pat[gi-1];
                assign w_shr[gi]      = 1'b0;
            end else begin : g_mid
                assign w_rot_left[gi] = r_pat[gi-1];
                assign w_shl[gi]      = r_pat[gi-1];
                assign w_shr[gi]      = r_pat[gi+1];
            end
        end
    endgenerate

    // Next-state logic. A load takes priority over a coincident tick.
    always_comb begin
        w_prescaler_next = r_prescaler + DIV_BITS'(1);
        w_pat_next       = r_pat;
        w_mode_next      = r_mode;
        w_dir_next       = r_dir;
        w_blink_on_next  = r_blink_on;

        if (cfg_load) begin
            w_prescaler_next = '0;
            w_pat_next       = cfg_pattern;
            w_mode_next      = cfg_mode;
            w_dir_next       = DIR_LEFT;
            w_blink_on_next  = 1'b1;
        end else if (w_tick) begin
            case (r_mode)
                MODE_BLINK:  w_blink_on_next = ~r_blink_on;
                MODE_ROTATE: w_pat_next      = w_rot_left;
                MODE_BOUNCE: begin
                    // Reverse when the lit edge bit reaches the end it is
                    // travelling towards, stepping back one place.
                    if (r_dir == DIR_LEFT) begin
                        if (r_pat[NUM_LEDS-1]) begin
                            w_dir_next = DIR_RIGHT;
                            w_pat_next = w_shr;
                        end else begin
                            w_pat_next = w_shl;
                        end
                    end else begin
                        if (r_pat[0]) begin
                            w_dir_next = DIR_LEFT;
                            w_pat_next = w_shl;
                        end else begin
                            w_pat_next = w_shr;
                        end
                    end
                end
                default: w_pat_next = r_pat;
            endcase
        end
    end

    // Visible pattern and global PWM gate.
    assign w_vis    = ((r_mode == MODE_BLINK) && !r_blink_on) ? '0 : r_pat;
    assign w_pwm_en = (brightness == PWM_MAX) || (r_pwm_cnt < brightness);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
            r_pat       <= RESET_PATTERN;
            r_mode      <= RESET_MODE;
            r_dir       <= DIR_LEFT;
            r_blink_on  <= 1'b1;
            r_step_tick <= 1'b0;
            r_led       <= '0;
        end else begin
            r_prescaler <= w_prescaler_next;
            r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
            r_pat       <= w_pat_next;
            r_mode      <= w_mode_next;
            r_dir       <= w_dir_next;
            r_blink_on  <= w_blink_on_next;
            // Registered so that step_tick tracks the prescaler value held
            // in the same cycle.
            r_step_tick <= (w_prescaler_next == PRESC_MAX);
            r_led       <= w_vis & {NUM_LEDS{w_pwm_en}};
        end
    end

    assign step_tick = r_step_tick;
    assign led       = r_led;

endmodule

// File: tb/tb_led_pattern_driver.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_driver
// Directed bench for led_pattern_driver with NUM_LEDS=4, DIV_BITS=2, PWM_BITS=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_led_pattern_driver;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cfg_load;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_pattern;
    logic [3:0] brightness;
    logic       step_tick;
    logic [3:0] led;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    led_pattern_driver #(
        .NUM_LEDS      (4),
        .DIV_BITS      (2),
        .PWM_BITS      (4),
        .RESET_PATTERN (4'b0001),
        .RESET_MODE    (2'd0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_load    (cfg_load),
        .cfg_mode    (cfg_mode),
        .cfg_pattern (cfg_pattern),
        .brightness  (brightness),
        .step_tick   (step_tick),
        .led         (led)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge right after the
    // capturing rising edge.
    task automatic do_load(input logic [1:0] m, input logic [3:0] p);
        cfg_mode    = m;
        cfg_pattern = p;
        cfg_load    = 1'b1;
        @(negedge clk);
        cfg_load    = 1'b0;
        $display("load mode=%0d pattern=%b", m, p);
    endtask

    // Each expected LED value is held for 4 samples; step_tick is high on the
    // third sample of each group (prescaler == 3).
    task automatic check_seq(input string tag, input logic [31:0] seq, input int nvals);
        logic [3:0] exp_led;
        for (int k = 0; k < nvals; k++) begin
            exp_led = seq[k*4 +: 4];
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check_val($sformatf("%s_led_s%0d_c%0d", tag, k, c), 32'(led), 32'(exp_led));
                check_val($sformatf("%s_tick_s%0d_c%0d", tag, k, c), 32'(step_tick), 32'(c == 2));
            end
            $display("%s step %0d led=%b expected=%b", tag, k, led, exp_led);
        end
    endtask

    task automatic pwm_count(input string tag, input logic [3:0] level, input int exp_on);
        int on_cnt;
        on_cnt = 0;
        brightness = level;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (led == 4'hF) on_cnt++;
            else if (led != 4'h0) check_val($sformatf("%s_level_%0d", tag, i), 32'(led), 32'h0);
        end
        check_val($sformatf("%s_on_count", tag), 32'(on_cnt), 32'(exp_on));
        $display("pwm brightness=%0d on=%0d of 32 expected=%0d", level, on_cnt, exp_on);
    endtask

    initial begin
        bit found;
        rstn        = 1'b0;
        cfg_load    = 1'b0;
        cfg_mode    = 2'd0;
        cfg_pattern = 4'b0000;
        brightness  = 4'hF;

        // Power-on reset and release
        repeat (3) @(negedge clk);
        check_val("por_led", 32'(led), 32'h0);
        check_val("por_tick", 32'(step_tick), 32'h0);
        rstn = 1'b1;
        check_seq("por_static", 32'h00000111, 3);

        // ROTATE
        do_load(2'd2, 4'b1001);
        check_seq("rotate", 32'h0009C639, 5);

        // Reset mid-animation, then release
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_val("midrst_led", 32'(led), 32'h0);
        check_val("midrst_tick", 32'(step_tick), 32'h0);
        $display("reset asserted mid-run led=%b tick=%b", led, step_tick);
        @(negedge clk);
        rstn = 1'b1;
        check_seq("after_rst", 32'h00000111, 3);

        // BOUNCE
        do_load(2'd3, 4'b0001);
        check_seq("bounce", 32'h21248421, 8);
        do_load(2'd3, 4'b0000);
        check_seq("bounce_zero", 32'h00000000, 3);

        // BLINK
        do_load(2'd1, 4'b1010);
        check_seq("blink", 32'h00000A0A, 4);
        do_load(2'd1, 4'b1010);
        check_seq("blink_on", 32'h0000000A, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val($sformatf("blink_off_%0d", i), 32'(led), 32'h0);
        end
        do_load(2'd1, 4'b1010);
        check_val("blink_reload_lat", 32'(led), 32'h0);
        check_seq("blink_reload", 32'h00000A0A, 4);

        // Load coincident with step_tick
        do_load(2'd2, 4'b0001);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (step_tick) found = 1'b1;
        end
        check_val("tick_wait", 32'(found), 32'h1);
        do_load(2'd2, 4'b0101);
        check_seq("load_on_tick", 32'h000005A5, 3);

        // PWM dimming
        do_load(2'd0, 4'b1111);
        pwm_count("pwm4", 4'd4, 8);
        pwm_count("pwm0", 4'd0, 0);
        pwm_count("pwm15", 4'd15, 32);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
